parking_gate_ctrl: RTL and testbench

Upstream front-end for the parking-lot occupancy block. Conditions raw gate sensors and the entry card reader, and decides whether an arriving car may enter using the lot's vacancy flags. Produces the single-cycle car_entered / car_exited event pulses, their uni/public qualifiers, and the time-of-day hour bus consumed by the occupancy block.

---
 rtl/parking_gate_if.sv | 34 +++
 rtl/parking_gate_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_if.sv
// Gate-side bundle for parking_gate_ctrl: raw sensors and card reader in,
// event pulses, barrier drives and time of day out.
interface parking_gate_if;
  logic       entry_sensor;
  logic       entry_card_valid;
  logic       entry_card_uni;
  logic       exit_sensor;
  logic       exit_card_uni;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic [5:0] hour;
  logic [5:0] minute;
  logic       entry_barrier_open;
  logic       exit_barrier_open;
  logic       entry_denied;

  modport master (
    output entry_sensor, entry_card_valid, entry_card_uni, exit_sensor,
           exit_card_uni, uni_is_vacated_space, is_vacated_space,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           hour, minute, entry_barrier_open, exit_barrier_open, entry_denied
  );

  modport slave (
    input  entry_sensor, entry_card_valid, entry_card_uni, exit_sensor,
           exit_card_uni, uni_is_vacated_space, is_vacated_space,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           hour, minute, entry_barrier_open, exit_barrier_open, entry_denied
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: sensor conditioning, entry admission, exit handling,
// event pulse generation and time-of-day for the occupancy block.
// Optional macro GATE_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stable-sample filter
// after the synchronizer.
module parking_gate_ctrl #(
  parameter int TICKS_PER_MIN   = 60,
  parameter int START_HOUR      = 8,
  parameter int ID_TIMEOUT      = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  parking_gate_if.slave gate
);
  localparam int TW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int IW = $clog2(ID_TIMEOUT);

  localparam logic [2:0] E_IDLE    = 3'd0;
  localparam logic [2:0] E_WAIT_ID = 3'd1;
  localparam logic [2:0] E_CHECK   = 3'd2;
  localparam logic [2:0] E_OPEN    = 3'd3;
  localparam logic [2:0] E_DENY    = 3'd4;
  localparam logic [0:0] X_IDLE    = 1'b0;
  localparam logic [0:0] X_OPEN    = 1'b1;

  // Out-of-range parameters elaborate this empty marker block.
  if (TICKS_PER_MIN < 1 || ID_TIMEOUT < 2 || DEBOUNCE_CYCLES < 1 ||
      START_HOUR < 0 || START_HOUR > 23) begin : g_bad_param
  end

  // Sensor lanes: bit 0 = entry, bit 1 = exit.
  logic [1:0] raw, sync1, sens_s, sens_q, sens_h, rise, fall;
  assign raw = {gate.exit_sensor, gate.entry_sensor};

  // Two-flop synchronizer; reset high so a sensor held through reset is no rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '1;
      sens_s <= '1;
    end else begin
      sync1  <= raw;
      sens_s <= sync1;
    end
  end

`ifdef GATE_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          lvl;
    // New level accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (sens_s[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= sens_s[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign sens_q[i] = lvl;
  end
`else
  assign sens_q = sens_s;
`endif

  // One-cycle history for edge detection, reset high like the synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) sens_h <= '1;
    else        sens_h <= sens_q;
  end
  assign rise = sens_q & ~sens_h;
  assign fall = ~sens_q & sens_h;

  // Free-running time of day.
  logic [TW-1:0] tick;
  logic [5:0]    minute_q, hour_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick     <= '0;
      minute_q <= '0;
      hour_q   <= 6'(START_HOUR);
    end else if (tick == TW'(TICKS_PER_MIN - 1)) begin
      tick <= '0;
      if (minute_q == 6'd59) begin
        minute_q <= '0;
        hour_q   <= (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
      end else begin
        minute_q <= minute_q + 6'd1;
      end
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Entry admission: wait for a card, check vacancy once, then open or deny.
  logic [2:0]    e_state;
  logic [IW-1:0] e_timer;
  logic          e_uni, grant;
  assign grant = e_uni ? (gate.uni_is_vacated_space | gate.is_vacated_space)
                       : gate.is_vacated_space;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_state <= E_IDLE;
      e_timer <= '0;
      e_uni   <= 1'b0;
    end else begin
      case (e_state)
        E_IDLE: if (rise[0]) begin
          e_state <= E_WAIT_ID;
          e_timer <= '0;
        end
        E_WAIT_ID: begin
          if (gate.entry_card_valid) begin
            e_uni   <= gate.entry_card_uni;
            e_state <= E_CHECK;
          end else if (fall[0]) begin
            e_state <= E_IDLE;
          end else if (e_timer == IW'(ID_TIMEOUT - 1)) begin
            e_state <= E_DENY;
          end else begin
            e_timer <= e_timer + 1'b1;
          end
        end
        // A car leaving mid-check must not leave the barrier open behind it.
        E_CHECK: e_state <= fall[0] ? E_IDLE : (grant ? E_OPEN : E_DENY);
        E_OPEN:  if (fall[0]) e_state <= E_IDLE;
        E_DENY:  if (fall[0]) e_state <= E_IDLE;
        default: e_state <= E_IDLE;
      endcase
    end
  end

  // Exit: every detected car is let out; class latched on arrival.
  logic [0:0] x_state;
  logic       x_uni;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_state <= X_IDLE;
      x_uni   <= 1'b0;
    end else if (x_state == X_IDLE) begin
      if (rise[1]) begin
        x_uni   <= gate.exit_card_uni;
        x_state <= X_OPEN;
      end
    end else if (fall[1]) begin
      x_state <= X_IDLE;
    end
  end

  logic ent_req, ex_req;
  assign ent_req = (e_state == E_OPEN) && fall[0];
  assign ex_req  = (x_state == X_OPEN) && fall[1];

  // Registered event pulses; exit wins a shared cycle, entry waits in pending slot.
  logic car_entered_q, uni_entered_q, car_exited_q, uni_exited_q;
  logic pend_vld, pend_uni;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_entered_q <= 1'b0;
      uni_entered_q <= 1'b0;
      car_exited_q  <= 1'b0;
      uni_exited_q  <= 1'b0;
      pend_vld      <= 1'b0;
      pend_uni      <= 1'b0;
    end else begin
      car_exited_q <= ex_req;
      uni_exited_q <= ex_req & x_uni;
      if (ex_req) begin
        car_entered_q <= 1'b0;
        uni_entered_q <= 1'b0;
        pend_vld      <= pend_vld | ent_req;
        pend_uni      <= pend_vld ? pend_uni : e_uni;
      end else begin
        car_entered_q <= pend_vld | ent_req;
        uni_entered_q <= pend_vld ? pend_uni : (ent_req & e_uni);
        pend_vld      <= pend_vld & ent_req;
        pend_uni      <= e_uni;
      end
    end
  end

  assign gate.car_entered        = car_entered_q;
  assign gate.is_uni_car_entered = uni_entered_q;
  assign gate.car_exited         = car_exited_q;
  assign gate.is_uni_car_exited  = uni_exited_q;
  assign gate.hour               = hour_q;
  assign gate.minute             = minute_q;
  assign gate.entry_barrier_open = (e_state == E_OPEN);
  assign gate.exit_barrier_open  = (x_state == X_OPEN);
  assign gate.entry_denied       = (e_state == E_DENY);
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl. Expected outputs come from a
// per-visit timeline derived from the gate rules (3-cycle sensor latency,
// card window, one-cycle check, exit-before-entry ordering) and from elapsed
// cycles for the clock.
module tb_parking_gate_ctrl;
  localparam int TPM   = 2;
  localparam int START = 8;
  localparam int IDTO  = 16;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  parking_gate_if bus ();

  parking_gate_ctrl #(
    .TICKS_PER_MIN(TPM), .START_HOUR(START), .ID_TIMEOUT(IDTO), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gate(bus)
  );

  always #5 clk = ~clk;

  // elapsed non-reset clock edges since the last reset
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic cmp(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk(input bit ebo, den, ce, ceu, xbo, cx, cxu);
    int m;
    m = (START * 60 + cyc / TPM) % 1440;
    cmp("hour", bus.hour, 6'(m / 60));
    cmp("minute", bus.minute, 6'(m % 60));
    cmp("entry_barrier_open", 6'(bus.entry_barrier_open), 6'(ebo));
    cmp("entry_denied", 6'(bus.entry_denied), 6'(den));
    cmp("car_entered", 6'(bus.car_entered), 6'(ce));
    cmp("is_uni_car_entered", 6'(bus.is_uni_car_entered), 6'(ceu));
    cmp("exit_barrier_open", 6'(bus.exit_barrier_open), 6'(xbo));
    cmp("car_exited", 6'(bus.car_exited), 6'(cx));
    cmp("is_uni_car_exited", 6'(bus.is_uni_car_exited), 6'(cxu));
  endtask

  // One entry visit plus an optional exit visit, checked every cycle.
  // Normal mode: sensor falls `hold` cycles after the decision is visible.
  // Abort mode: no card, sensor falls at `hold` while still waiting for a card.
  // xf < 0 makes the exit sensor fall on the same cycle as the entry sensor.
  task automatic visit(input bit uni, input int cd_in, input bit uvac, input bit pvac,
                       input bit abort_m, input int hold,
                       input bit x_en, input bit xuni, input int xr, input int xf);
    int  cd, dec, tf, xfa, e_ev, tend;
    bit  acc, open, act;
    cd   = abort_m ? -1 : cd_in;
    // card is sampled one edge after it is driven; FSM waits from edge LAT
    acc  = (cd >= LAT) && (cd <= LAT + IDTO - 1);
    dec  = acc ? cd + 2 : LAT + IDTO;
    open = acc && (uni ? (uvac | pvac) : pvac);
    tf   = abort_m ? hold : dec - LAT + hold;
    xfa  = (xf < 0) ? tf : xf;
    e_ev = (!abort_m && open) ? tf + LAT + ((x_en && xfa == tf) ? 1 : 0) : -100;
    tend = tf;
    if (x_en && xfa > tend) tend = xfa;
    if (cd > tend) tend = cd;
    tend += 8;
    bus.uni_is_vacated_space = uvac;
    bus.is_vacated_space     = pvac;
    bus.exit_card_uni        = xuni;
    for (int t = 0; t <= tend; t++) begin
      @(negedge clk);
      act = !abort_m && t >= dec && t < tf + LAT;
      chk(act && open, act && !open, t == e_ev, (t == e_ev) && uni,
          x_en && t >= xr + LAT && t < xfa + LAT, x_en && t == xfa + LAT,
          x_en && t == xfa + LAT && xuni);
      if (t == 0) bus.entry_sensor = 1'b1;
      if (t == tf) bus.entry_sensor = 1'b0;
      bus.entry_card_valid = (t == cd);
      bus.entry_card_uni   = (t == cd) ? uni : 1'($urandom);
      if (x_en && t == xr)  bus.exit_sensor = 1'b1;
      if (x_en && t == xfa) bus.exit_sensor = 1'b0;
      if (!abort_m && t >= dec) begin
        bus.uni_is_vacated_space = 1'($urandom);
        bus.is_vacated_space     = 1'($urandom);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.entry_sensor = 1'b0;
    bus.entry_card_valid = 1'b0;
    bus.entry_card_uni = 1'b0;
    bus.exit_sensor = 1'b0;
    bus.exit_card_uni = 1'b0;
    bus.uni_is_vacated_space = 1'b0;
    bus.is_vacated_space = 1'b0;

    // reset state
    repeat (3) begin
      @(negedge clk);
      chk(0, 0, 0, 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk(0, 0, 0, 0, 0, 0, 0);
    end

    // uni card at +5 with a uni space free -> open, one uni entry event
    visit(1, 5, 1, 0, 0, 4, 0, 0, 0, 0);
    // public card, no public space -> denied, no event
    visit(0, 5, 1, 0, 0, 5, 0, 0, 0, 0);
    // no card within the window, late card ignored -> denied
    visit(1, 20, 1, 1, 0, 6, 0, 0, 0, 0);
    // card-window boundaries: just too early, first, last, just too late
    visit(0, 2, 1, 1, 0, 3, 0, 0, 0, 0);
    visit(0, 3, 0, 1, 0, 3, 0, 0, 0, 0);
    visit(1, 18, 0, 1, 0, 3, 0, 0, 0, 0);
    visit(1, 19, 1, 1, 0, 3, 0, 0, 0, 0);
    // simultaneous falls: uni exit first, public entry next cycle
    visit(0, 4, 0, 1, 0, 5, 1, 1, 0, -1);
    // car leaves while waiting for its card
    visit(1, 0, 1, 1, 1, 6, 0, 0, 0, 0);

    // randomized visits
    for (int i = 0; i < 30; i++) begin
      bit ab, xe, xc;
      int xr_r;
      ab   = ($urandom_range(0, 4) == 0);
      xe   = 1'($urandom);
      xc   = 1'($urandom);
      xr_r = xc ? 0 : $urandom_range(0, 4);
      visit(1'($urandom), $urandom_range(0, 22), 1'($urandom), 1'($urandom),
            ab, ab ? $urandom_range(1, IDTO - 2) : $urandom_range(1, 8),
            xe, 1'($urandom), xr_r, xc ? -1 : xr_r + 1 + $urandom_range(0, 10));
    end

    // reset while the entry barrier is open and the sensor is held
    bus.uni_is_vacated_space = 1'b1;
    bus.is_vacated_space     = 1'b1;
    for (int t = 0; t <= 25; t++) begin
      @(negedge clk);
      chk(t >= 6 && t < 10, 0, 0, 0, 0, 0, 0);
      if (t == 0) bus.entry_sensor = 1'b1;
      bus.entry_card_valid = (t == 4);
      bus.entry_card_uni   = 1'b0;
      if (t == 9)  rst_n = 1'b0;
      if (t == 11) rst_n = 1'b1;
      if (t == 19) bus.entry_sensor = 1'b0;
    end
    // fresh press after release is handled from the start
    visit(1, 6, 1, 0, 0, 3, 0, 0, 0, 0);

    // long clock run through midnight
    rst_n = 1'b0;
    @(negedge clk);
    chk(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 1925; k++) begin
      @(negedge clk);
      chk(0, 0, 0, 0, 0, 0, 0);
      if (cyc == 60 * TPM) begin
        cmp("hour_at_9", bus.hour, 6'd9);
        cmp("minute_at_9", bus.minute, 6'd0);
      end
      if (cyc == 960 * TPM - 1) begin
        cmp("hour_at_2359", bus.hour, 6'd23);
        cmp("minute_at_2359", bus.minute, 6'd59);
      end
      if (cyc == 960 * TPM) begin
        cmp("hour_wrap", bus.hour, 6'd0);
        cmp("minute_wrap", bus.minute, 6'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
